// File: rtl/tx_ibuf_rdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_ibuf_rdr_pkg
// Brief    : Shared constants, FSM encoding and read-tag type for the TX
//            internal-buffer reader.
// Revision : 1.0 - initial release
// ============================================================================
package tx_ibuf_rdr_pkg;

  // Header word layout: byte length lives in the low 16 bits
  localparam int LEN_LSB      = 0;
  localparam int LEN_MSB      = 15;
  localparam int OFIFO_DEPTH  = 4;
  localparam int READ_LATENCY = 2;
  // tdata(64) + tkeep(8) + tlast(1)
  localparam int OFIFO_W      = 73;
  // Packet-end values waiting for their tlast handshake
  localparam int END_SLOTS    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } rdr_state_e;

  // Attributes travelling alongside an outstanding buffer read
  typedef struct packed {
    logic       vld;
    logic       hdr;
    logic       last;
    logic [7:0] keep;
  } rd_tag_t;

  // Byte enables for the final word of a packet given len[2:0]
  function automatic logic [7:0] last_keep(input logic [2:0] tail);
    return (tail == 3'd0) ? 8'hFF : 8'((9'd1 << tail) - 9'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_ibuf_ofifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_ibuf_ofifo
// Brief    : Small synchronous output FIFO holding {tdata, tkeep, tlast}.
//            Registered output; a simultaneous push into an empty FIFO is
//            visible the following cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tx_ibuf_ofifo
  import tx_ibuf_rdr_pkg::*;
#(
  parameter int W     = OFIFO_W,
  parameter int DEPTH = OFIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for storage, indices and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_idx_q] = din;
      wr_idx_d        = wr_idx_q + IDX_W'(1);
    end
    if (pop) begin
      rd_idx_d = rd_idx_q + IDX_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Index/occupancy registers; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_idx_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/tx_ibuf_rdr.sv
`default_nettype none
// ============================================================================
// Module   : tx_ibuf_rdr
// Brief    : Fetches length-prefixed packets from the TX internal buffer,
//            hides the 2-cycle read latency behind a credit-controlled
//            output FIFO, streams them as AXI4-Stream and releases buffer
//            space on each tlast handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tx_ibuf_rdr
  import tx_ibuf_rdr_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW:0]   wr_ptr,
  output logic [AW:0]   rd_ptr,
  output logic [AW-1:0] dpra,
  input  logic [DW-1:0] qdpo,
  output logic [63:0]   m_axis_tdata,
  output logic [7:0]    m_axis_tkeep,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  output logic          hdr_err
);

  localparam int CNT_W = $clog2(OFIFO_DEPTH+1);
  // Enough for nwords of a 65535-byte packet (8192)
  localparam int REM_W = 14;

  rdr_state_e                     state_q, state_d;
  logic [AW:0]                    fetch_ptr_q, fetch_ptr_d;
  logic [AW:0]                    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]                  dpra_q, dpra_d;
  logic [REM_W-1:0]               remaining_q, remaining_d;
  logic [2:0]                     tail_q, tail_d;
  logic [END_SLOTS-1:0][AW:0]     end_q, end_d;
  logic [1:0]                     end_cnt_q, end_cnt_d;
  rd_tag_t [READ_LATENCY-1:0]     pipe_q, pipe_d;
  logic                           hdr_err_q, hdr_err_d;

  logic [AW:0]        avail;
  logic [15:0]        hdr_len;
  logic [REM_W-1:0]   nwords;
  logic [AW:0]        pkt_end;
  rd_tag_t            issue_tag;
  rd_tag_t            ret_tag;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic               credit_ok;
  logic               issue;
  logic               end_push;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               last_hs;
  logic [OFIFO_W-1:0] fifo_dout;

  assign avail   = wr_ptr - fetch_ptr_q;
  assign hdr_len = qdpo[LEN_MSB:LEN_LSB];
  assign nwords  = REM_W'(({1'b0, hdr_len} + 17'd7) >> 3);
  // fetch_ptr already points one past the header while in HDR
  assign pkt_end = fetch_ptr_q + (AW+1)'(nwords);
  assign ret_tag = pipe_q[READ_LATENCY-1];

  // Count data reads still travelling through the RAM pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      if (pipe_q[i].vld && !pipe_q[i].hdr) inflight = inflight + CNT_W'(1);
    end
  end

  // Every outstanding read has a reserved FIFO slot, so pushes never overflow
  assign credit_ok = (fifo_count + inflight) < CNT_W'(OFIFO_DEPTH);

  // Fetch FSM: header fetch, length decode, data read issue
  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    dpra_d      = dpra_q;
    remaining_d = remaining_q;
    tail_d      = tail_q;
    hdr_err_d   = 1'b0;
    end_push    = 1'b0;
    issue       = 1'b0;
    issue_tag   = '0;
    case (state_q)
      IDLE: begin
        // Hold off a new header while both packet-end slots are occupied
        if ((avail != '0) && (end_cnt_q < 2'(END_SLOTS))) begin
          issue         = 1'b1;
          issue_tag.vld = 1'b1;
          issue_tag.hdr = 1'b1;
          state_d       = HDR;
        end
      end
      HDR: begin
        if (ret_tag.vld && ret_tag.hdr) begin
          if (hdr_len == 16'd0) begin
            hdr_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            remaining_d = nwords;
            tail_d      = hdr_len[2:0];
            end_push    = 1'b1;
            state_d     = DATA;
          end
        end
      end
      DATA: begin
        if ((avail != '0) && credit_ok) begin
          issue          = 1'b1;
          issue_tag.vld  = 1'b1;
          issue_tag.last = (remaining_q == REM_W'(1));
          issue_tag.keep = issue_tag.last ? last_keep(tail_q) : 8'hFF;
          remaining_d    = remaining_q - REM_W'(1);
          if (remaining_q == REM_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      fetch_ptr_d = fetch_ptr_q + (AW+1)'(1);
      dpra_d      = fetch_ptr_q[AW-1:0];
    end
  end

  // Tag shift register mirrors the RAM's read latency
  always_comb begin
    pipe_d = {pipe_q[READ_LATENCY-2:0], issue_tag};
  end

  // Packet-end queue and release pointer
  always_comb begin
    end_d     = end_q;
    end_cnt_d = end_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    if (last_hs) begin
      rd_ptr_d  = end_q[0];
      end_d[0]  = end_q[1];
      end_cnt_d = end_cnt_q - 2'd1;
    end
    if (end_push) begin
      end_d[end_cnt_d[0]] = pkt_end;
      end_cnt_d           = end_cnt_d + 2'd1;
    end
  end

  // State registers; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_ptr_q <= '0;
      rd_ptr_q    <= '0;
      dpra_q      <= '0;
      remaining_q <= '0;
      tail_q      <= '0;
      end_q       <= '0;
      end_cnt_q   <= '0;
      pipe_q      <= '0;
      hdr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dpra_q      <= dpra_d;
      remaining_q <= remaining_d;
      tail_q      <= tail_d;
      end_q       <= end_d;
      end_cnt_q   <= end_cnt_d;
      pipe_q      <= pipe_d;
      hdr_err_q   <= hdr_err_d;
    end
  end

  assign fifo_push = ret_tag.vld && !ret_tag.hdr;
  assign fifo_pop  = m_axis_tvalid && m_axis_tready;
  assign last_hs   = fifo_pop && m_axis_tlast;

  tx_ibuf_ofifo #(
    .W     (OFIFO_W),
    .DEPTH (OFIFO_DEPTH)
  ) u_ofifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({qdpo, ret_tag.keep, ret_tag.last}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_axis_tdata  = fifo_dout[OFIFO_W-1:9];
  assign m_axis_tkeep  = fifo_dout[8:1];
  assign m_axis_tlast  = fifo_dout[0];
  assign m_axis_tvalid = !fifo_empty;
  assign rd_ptr        = rd_ptr_q;
  assign dpra          = dpra_q;
  assign hdr_err       = hdr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_ibuf_rdr.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_ibuf_rdr
// Brief    : Self-checking bench for tx_ibuf_rdr. A behavioural writer fills a
//            buffer model and queues the beats/release pointers each packet
//            must produce; a monitor compares the AXI stream against them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_ibuf_rdr;

  localparam int AW          = 10;
  localparam int DRAIN_LIMIT = 5000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW:0]   wr_ptr = '0;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] dpra;
  logic [63:0]   qdpo;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          hdr_err;

  int n_checks = 0;
  int n_errors = 0;

  tx_ibuf_rdr #(.AW(AW), .DW(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_ptr        (wr_ptr),
    .rd_ptr        (rd_ptr),
    .dpra          (dpra),
    .qdpo          (qdpo),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .hdr_err       (hdr_err)
  );

  always #5 clk = ~clk;

  // Buffer model: registered read data from the registered address
  logic [63:0] mem [1<<AW];
  always @(posedge clk) qdpo <= mem[dpra];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected stream, built by the writer
  logic [63:0] q_data [$];
  logic [7:0]  q_keep [$];
  logic        q_last [$];
  logic [AW:0] q_end  [$];
  logic [AW:0] wp = '0;

  // Write one packet into the buffer model and record what it must produce
  task automatic put_pkt(input int len);
    int nw;
    nw = (len + 7) / 8;
    mem[wp[AW-1:0]] = {$urandom, 16'($urandom), 16'(len)};
    wp = wp + 1'b1;
    for (int i = 0; i < nw; i++) begin
      logic [63:0] d;
      logic [15:0] k16;
      int bytes;
      d = {$urandom, $urandom};
      bytes = len - 8 * i;
      if (bytes > 8) bytes = 8;
      k16 = (16'd1 << bytes) - 16'd1;
      mem[wp[AW-1:0]] = d;
      q_data.push_back(d);
      q_keep.push_back(k16[7:0]);
      q_last.push_back(8 * (i + 1) >= len);
      wp = wp + 1'b1;
    end
    if (nw > 0) q_end.push_back(wp);
  endtask

  task automatic commit();
    @(posedge clk);
    #1 wr_ptr = wp;
  endtask

  // tready pattern: 0 = always ready, 1 = random 50%, 2 = held low
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor / scoreboard
  int          hs_cyc [$];
  int          n_hdr_err = 0;
  bit          pend = 1'b0;
  logic [AW:0] pend_val;
  bit          stall = 1'b0;
  logic [63:0] snap_data;
  logic [8:0]  snap_ctl;
  logic [63:0] ed;
  logic [7:0]  ek;
  logic        el;

  always @(negedge clk) begin
    if (reset) begin
      pend  = 1'b0;
      stall = 1'b0;
    end else begin
      if (pend) begin
        check("release_rd_ptr", rd_ptr, pend_val);
        pend = 1'b0;
      end
      if (stall) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_tdata", m_axis_tdata, snap_data);
        check("hold_tkeep_tlast", {m_axis_tkeep, m_axis_tlast}, snap_ctl);
      end
      if (hdr_err) n_hdr_err++;
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cyc.push_back(cyc);
        check("beat_expected", q_data.size() != 0, 1);
        if (q_data.size() != 0) begin
          ed = q_data.pop_front();
          ek = q_keep.pop_front();
          el = q_last.pop_front();
          check("tdata", m_axis_tdata, ed);
          check("tkeep", m_axis_tkeep, ek);
          check("tlast", m_axis_tlast, el);
          if (el && q_end.size() != 0) begin
            pend     = 1'b1;
            pend_val = q_end.pop_front();
          end
        end
      end
      stall     = m_axis_tvalid && !m_axis_tready;
      snap_data = m_axis_tdata;
      snap_ctl  = {m_axis_tkeep, m_axis_tlast};
    end
  end

  // Wait until every expected beat and release has been observed
  task automatic drain();
    int n;
    n = 0;
    while ((q_data.size() != 0 || pend) && n < DRAIN_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", n < DRAIN_LIMIT, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int          n;
    int          e0;
    int          fill;
    logic [AW:0] base;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_rd_ptr", rd_ptr, 0);
    check("rst_dpra", dpra, 0);
    check("rst_hdr_err", hdr_err, 0);

    // Single 60-byte packet at address 0
    hs_cyc.delete();
    put_pkt(60);
    commit();
    n = 0;
    @(negedge clk);
    while (!m_axis_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_beat_latency", n, 6);
    drain();
    check("single_beats", hs_cyc.size(), 8);
    check("single_rd_ptr", rd_ptr, 9);

    // 64-byte then 1-byte packet, back to back
    hs_cyc.delete();
    base = wp;
    put_pkt(64);
    put_pkt(1);
    commit();
    drain();
    check("b2b_beats", hs_cyc.size(), 9);
    check("b2b_gap", hs_cyc[8] - hs_cyc[7], 4);
    check("b2b_rd_ptr", rd_ptr, base + 11'd11);

    // Zero-length header followed by an 8-byte packet
    e0 = n_hdr_err;
    put_pkt(0);
    put_pkt(8);
    commit();
    drain();
    check("hdr_err_pulses", n_hdr_err - e0, 1);
    check("after_len0_rd_ptr", rd_ptr, wp);

    // Long packet and random batches under 50% tready
    rdy_mode = 1;
    put_pkt(1500);
    commit();
    drain();
    check("long_rd_ptr", rd_ptr, wp);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 3; k++) begin
        put_pkt(int'($urandom_range(1, 200)));
        commit();
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
      drain();
      check("batch_rd_ptr", rd_ptr, wp);
    end

    // Pad so the next header lands at word 1020, then wrap
    rdy_mode = 0;
    fill = 1020 - int'(wp);
    put_pkt((fill - 1) * 8);
    commit();
    drain();
    check("pre_wrap_rd_ptr", rd_ptr, 1020);
    put_pkt(64);
    commit();
    drain();
    check("wrap_rd_ptr", rd_ptr, 11'h405);

    // Reset in the middle of a stalled packet
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    put_pkt(200);
    commit();
    repeat (12) @(negedge clk);
    check("pre_reset_tvalid", m_axis_tvalid, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    wr_ptr = '0;
    wp = '0;
    q_data.delete();
    q_keep.delete();
    q_last.delete();
    q_end.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_rd_ptr", rd_ptr, 0);
    check("mid_rst_dpra", dpra, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    rdy_mode = 0;
    hs_cyc.delete();
    put_pkt(60);
    commit();
    drain();
    check("restart_beats", hs_cyc.size(), 8);
    check("restart_rd_ptr", rd_ptr, 9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
